main_mem_responder: RTL and testbench
=====================================

# main_mem_responder

- Responder end of the cache-fill read protocol: a word-organised main memory that accepts one read or write per cycle and returns read data after a fixed latency with a one-cycle valid strobe.
- Fully pipelined: up to LATENCY reads in flight, no back-pressure.
- Sits behind the cache fill FSM, which issues eight back-to-back reads per 16-byte block and counts returned words on `data_valid`.
- Also serves as the behavioural main-memory model in processor-level benches.

## Interface
- ADDR_W, 16, byte address width; bit 0 ignored (16-bit words).
- DATA_W, 16, data word width.
- MEM_AW, 15, word-array index width; array holds 2^MEM_AW words, indexed by addr[MEM_AW:1].
- LATENCY, 4, cycles from request to data; legal range 1..8.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- read_req  in  1  read request, sampled each rising edge.
- wr  in  1  write enable, sampled each rising edge.
- addr  in  ADDR_W  request address, used by both read and write.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  returned read data; 0 when data_valid is low.
- data_valid  out  1  read data valid this cycle.
- outstanding  out  4  number of reads in flight, 0..LATENCY.
- err  out  1  sticky flag: read_req and wr were sampled high together.

## Operation
- **Reset (rst low):**
  - All pipeline valid bits cleared.
  - data_valid=0, data_out=0, outstanding=0, err=0.
  - Array contents are not reset and keep their values across reset.
- **Read:**
  - read_req=1 and wr=0 at edge E: the word at addr[MEM_AW:1] is captured into pipeline stage 1 at edge E, together with a valid bit.
  - Each stage advances one position every edge, unconditionally.
- **Return:** data_valid = valid bit of stage LATENCY, and data_out = that stage's data.
- **Write:**
  - wr=1 and read_req=0 at edge E: the array word is updated at edge E.
  - Writes do not enter the pipeline and produce no response.
- **Ordering:**
  - Read data is the array value sampled at the request edge.
  - A write to the same address on the cycle after a read does not change that read's returned data.
  - A read issued on the cycle after a write returns the new data.
- **Conflict:**
  - read_req=1 and wr=1 at the same edge: the write is performed, the read is dropped (no valid enters the pipeline), and err is set.
  - err stays 1 until reset.
- **Counting:**
  - outstanding = number of set valid bits across stages 1..LATENCY.
  - It is updated every edge as +1 on issue and −1 on retire; simultaneous issue and retire leaves it unchanged.
- **No stall input:** the requester must accept data on every cycle that data_valid=1.

## Timing
- Request sampled at edge E (read_req high during cycle c) gives data_valid=1 and data_out valid during cycle c+LATENCY, i.e. after edge E+LATENCY−1.
- Back-to-back requests on cycles c..c+7 give data_valid high on cycles c+LATENCY..c+LATENCY+7, contiguous and in order.
- Throughput: one read per cycle, sustained indefinitely.
- All outputs come straight from registers; no combinational path from any input to any output.
- Reset asserted mid-burst: in-flight reads are discarded immediately (asynchronous). No data_valid pulse for them after rst rises.
- First request after rst deasserts behaves as from idle.

## Structure
- Shared package `mem_pkg` holds:
  - ADDR_W / DATA_W / LATENCY defaults.
  - The word-index slice helper constant (MEM_AW).
  - The in-flight stage struct {valid, data}.
- Sub-module `mem_lat_pipe` holds the LATENCY-deep {valid, data} shift register with async active-low clear and exposes its valid vector.
- The top level holds the storage array, request decode, conflict detect, err flag and outstanding counter.

## Test plan
- **Single read.** Preload word 0x0123 at addr 0x1A42 via write, then read_req on addr 0x1A42 in cycle 10. Required: data_valid=1 with data_out=0x0123 only in cycle 14; outstanding goes 1,1,1,1,0 over cycles 11–15.
- **Eight-word burst.** Preload addr 0x2000..0x200E with 0xA000..0xA007, then issue read_req on cycles 20–27 with addr stepping by 2. Required: data_valid high on cycles 24–31 with data 0xA000..0xA007 in order; outstanding peaks at 4.
- **Read/write ordering on 0x3004 (initially 0x1111):** read in cycle 5, write 0x2222 in cycle 6, read in cycle 7. Required: returns 0x1111 in cycle 9 and 0x2222 in cycle 11.
- **Conflict.** read_req=1 and wr=1 with data 0xBEEF at addr 0x0040 in the same cycle. Required: no data_valid 4 cycles later, err=1 from the next cycle and held, and a later read of 0x0040 returns 0xBEEF.
- **Reset mid-burst.** Pull rst low for one cycle after 3 reads of a burst are issued. Required: data_valid=0, outstanding=0 and err=0 immediately, and no stray valid afterwards. A new read then returns correct data at LATENCY, and array contents are unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory responder: default sizes and pipeline stage type.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_LATENCY = 4;

  // Word index is addr[DEF_MEM_AW:WORD_LSB]; bit 0 selects a byte within a 16-bit word.
  localparam int DEF_MEM_AW  = 15;
  localparam int WORD_LSB    = 1;

  // One in-flight read: valid bit plus the word captured at the request edge.
  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] data;
  } mem_stage_t;

endpackage

// File: rtl/mem_lat_pipe.sv
// Fixed-depth {valid, data} shift register carrying reads from request to response.
// Latency: LATENCY edges from i_stage to o_stage.
// Backpressure: none; every stage advances on every edge.
module mem_lat_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  mem_stage_t         i_stage,
  output mem_stage_t         o_stage,
  output logic [LATENCY-1:0] o_vld_vec
);

  mem_stage_t r_stage [LATENCY];

  // Shift every stage one place per edge; reset drops all in-flight reads at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_stage;
      for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_stage = r_stage[LATENCY-1];

  // Gather per-stage valid bits so the parent can see occupancy.
  always_comb begin
    o_vld_vec = '0;
    for (int i = 0; i < LATENCY; i++) o_vld_vec[i] = r_stage[i].valid;
  end

endmodule

// File: rtl/main_mem_responder.sv
// Word-organised main memory answering one read or write per cycle with a fixed-latency response.
// Latency: read data valid LATENCY cycles after the request cycle; writes produce no response.
// Backpressure: none; requester must take data_valid whenever it is high.
module main_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  // Must equal DEF_DATA_W: the stage struct carried by the pipe is sized from it.
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_AW  = DEF_MEM_AW,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [3:0]        outstanding,
  output logic              err
);

  // Storage is deliberately not reset so contents survive a reset pulse.
  logic [DATA_W-1:0] r_mem [2**MEM_AW];

  logic [MEM_AW-1:0]  w_idx;
  logic               w_issue;
  logic               w_retire;
  logic               w_conflict;
  mem_stage_t         w_stage_in;
  mem_stage_t         w_stage_out;
  logic [LATENCY-1:0] w_vld_vec;
  logic               w_unused;
  logic [3:0]         r_outstanding;
  logic               r_err;

  assign w_idx      = addr[MEM_AW:WORD_LSB];
  // A simultaneous read and write keeps the write and drops the read.
  assign w_issue    = read_req & ~wr;
  assign w_conflict = read_req & wr;
  // The tail stage's valid bit leaves the pipe at the next edge.
  assign w_retire   = w_vld_vec[LATENCY-1];
  // Byte-select bit and interior valids are not needed for any decision here.
  assign w_unused   = ^{addr[0], w_vld_vec};

  // Array write; a same-edge read sees the old word since the read is sampled before the update.
  always_ff @(posedge clk) begin
    if (wr) r_mem[w_idx] <= data_in;
  end

  // Build the stage-1 entry; non-read cycles inject zero data so data_out is 0 when idle.
  always_comb begin
    w_stage_in = '0;
    if (w_issue) begin
      w_stage_in.valid = 1'b1;
      w_stage_in.data  = r_mem[w_idx];
    end
  end

  mem_lat_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_stage   (w_stage_in),
    .o_stage   (w_stage_out),
    .o_vld_vec (w_vld_vec)
  );

  // Track reads in flight: +1 on issue, -1 as the tail stage retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_outstanding <= '0;
    else      r_outstanding <= r_outstanding + {3'b000, w_issue} - {3'b000, w_retire};
  end

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_err <= 1'b0;
    else if (w_conflict) r_err <= 1'b1;
  end

  assign data_valid  = w_stage_out.valid;
  assign data_out    = w_stage_out.data;
  assign outstanding = r_outstanding;
  assign err         = r_err;

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder against a deadline-queue memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_main_mem_responder;

  localparam int L = 4;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        read_req = 1'b0;
  logic        wr       = 1'b0;
  logic [15:0] addr     = '0;
  logic [15:0] data_in  = '0;
  logic [15:0] data_out;
  logic        data_valid;
  logic [3:0]  outstanding;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: word store, queue of (due edge, data) for reads in flight, sticky error.
  logic [15:0] m_mem [int];
  int          q_due [$];
  logic [15:0] q_dat [$];
  bit          m_err = 1'b0;

  logic        exp_vld;
  logic [15:0] exp_dat;
  logic [3:0]  exp_out;
  logic        exp_err;

  main_mem_responder #(.LATENCY(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .read_req    (read_req),
    .wr          (wr),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .outstanding (outstanding),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rq, input logic w, input logic [15:0] a, input logic [15:0] d);
    read_req = rq;
    wr       = w;
    addr     = a;
    data_in  = d;
  endtask

  // Advance one edge, update the model from the sampled inputs, leave us at the next negedge.
  task automatic tick();
    int idx;
    @(posedge clk);
    cyc++;
    idx = int'(addr[15:1]);
    if (!rst) begin
      q_due.delete();
      q_dat.delete();
      m_err = 1'b0;
    end else if (wr) begin
      m_mem[idx] = data_in;
      if (read_req) m_err = 1'b1;
    end else if (read_req) begin
      q_due.push_back(cyc + L - 1);
      q_dat.push_back(m_mem.exists(idx) ? m_mem[idx] : 16'h0000);
    end
    exp_out = 4'(q_due.size());
    exp_vld = (q_due.size() > 0) && (q_due[0] == cyc);
    exp_dat = exp_vld ? q_dat[0] : 16'h0000;
    exp_err = m_err;
    if (exp_vld) begin
      void'(q_due.pop_front());
      void'(q_dat.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) tick();
    n_checks++;
    if (data_valid !== 1'b0 || data_out !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_resp vld=%0b dat=%h expected vld=0 dat=0000", data_valid, data_out);
    end
    n_checks++;
    if (outstanding !== 4'd0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state outstanding=%0d err=%0b expected 0 0", outstanding, err);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    int hit_k = -1;
    int hits  = 0;
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'd1; exp_seq[1] = 4'd1; exp_seq[2] = 4'd1; exp_seq[3] = 4'd1; exp_seq[4] = 4'd0;
    drive(1'b0, 1'b1, 16'h1A42, 16'h0123);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) drive(1'b1, 1'b0, 16'h1A42, 16'h0);
      else        drive(1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      n_checks++;
      if (data_valid !== exp_vld || data_out !== exp_dat) begin
        n_errors++;
        $display("FAIL single_resp k=%0d vld=%0b dat=%h expected vld=%0b dat=%h", k, data_valid, data_out, exp_vld, exp_dat);
      end
      if (k < 5) begin
        n_checks++;
        if (outstanding !== exp_seq[k]) begin
          n_errors++;
          $display("FAIL single_outstanding k=%0d got=%0d expected=%0d", k, outstanding, exp_seq[k]);
        end
      end
      if (data_valid === 1'b1) begin
        hits++;
        hit_k = k;
        n_checks++;
        if (data_out !== 16'h0123) begin
          n_errors++;
          $display("FAIL single_data got=%h expected=0123", data_out);
        end
      end
    end
    n_checks++;
    if (hits != 1 || hit_k != L - 1) begin
      n_errors++;
      $display("FAIL single_timing pulses=%0d at_k=%0d expected 1 at_k=%0d", hits, hit_k, L - 1);
    end
  endtask

  task automatic test_burst();
    logic [15:0] got [$];
    int first_k = -1;
    int max_out = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 16'h2000 + 16'(2 * i), 16'hA000 + 16'(i));
      tick();
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    for (int k = 0; k < 14; k++) begin
      if (k < 8) drive(1'b1, 1'b0, 16'h2000 + 16'(2 * k), 16'h0);
      else       drive(1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      n_checks++;
      if (data_valid !== exp_vld || data_out !== exp_dat || outstanding !== exp_out) begin
        n_errors++;
        $display("FAIL burst_cycle k=%0d vld=%0b dat=%h out=%0d expected vld=%0b dat=%h out=%0d",
                 k, data_valid, data_out, outstanding, exp_vld, exp_dat, exp_out);
      end
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
      if (data_valid === 1'b1) begin
        if (first_k < 0) first_k = k;
        got.push_back(data_out);
      end
    end
    n_checks++;
    if (got.size() != 8 || first_k != L - 1) begin
      n_errors++;
      $display("FAIL burst_count words=%0d first_k=%0d expected 8 first_k=%0d", got.size(), first_k, L - 1);
    end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      n_checks++;
      if (got[i] !== 16'hA000 + 16'(i)) begin
        n_errors++;
        $display("FAIL burst_order idx=%0d got=%h expected=%h", i, got[i], 16'hA000 + 16'(i));
      end
    end
    n_checks++;
    if (max_out != L) begin
      n_errors++;
      $display("FAIL burst_peak got=%0d expected=%0d", max_out, L);
    end
  endtask

  task automatic test_ordering();
    logic [15:0] got [$];
    int got_k [$];
    drive(1'b0, 1'b1, 16'h3004, 16'h1111);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    for (int k = 0; k < 9; k++) begin
      case (k)
        0:       drive(1'b1, 1'b0, 16'h3004, 16'h0);
        1:       drive(1'b0, 1'b1, 16'h3004, 16'h2222);
        2:       drive(1'b1, 1'b0, 16'h3004, 16'h0);
        default: drive(1'b0, 1'b0, 16'h0, 16'h0);
      endcase
      tick();
      n_checks++;
      if (data_valid !== exp_vld || data_out !== exp_dat || outstanding !== exp_out) begin
        n_errors++;
        $display("FAIL order_cycle k=%0d vld=%0b dat=%h out=%0d expected vld=%0b dat=%h out=%0d",
                 k, data_valid, data_out, outstanding, exp_vld, exp_dat, exp_out);
      end
      if (data_valid === 1'b1) begin
        got.push_back(data_out);
        got_k.push_back(k);
      end
    end
    n_checks++;
    if (got.size() != 2) begin
      n_errors++;
      $display("FAIL order_count got=%0d expected=2", got.size());
    end else begin
      n_checks++;
      if (got[0] !== 16'h1111 || got[1] !== 16'h2222 || got_k[0] != 3 || got_k[1] != 5) begin
        n_errors++;
        $display("FAIL order_data got=%h@%0d %h@%0d expected 1111@3 2222@5", got[0], got_k[0], got[1], got_k[1]);
      end
    end
  endtask

  task automatic test_conflict();
    int pulses = 0;
    logic [15:0] rd = 16'h0;
    drive(1'b1, 1'b1, 16'h0040, 16'hBEEF);
    tick();
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++;
      $display("FAIL conflict_err got=%0b expected=1", err);
    end
    for (int k = 1; k < 7; k++) begin
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      if (data_valid === 1'b1) pulses++;
      n_checks++;
      if (data_valid !== exp_vld || err !== 1'b1 || outstanding !== exp_out) begin
        n_errors++;
        $display("FAIL conflict_hold k=%0d vld=%0b err=%0b out=%0d expected vld=%0b err=1 out=%0d",
                 k, data_valid, err, outstanding, exp_vld, exp_out);
      end
    end
    n_checks++;
    if (pulses != 0) begin
      n_errors++;
      $display("FAIL conflict_no_resp pulses=%0d expected=0", pulses);
    end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) drive(1'b1, 1'b0, 16'h0040, 16'h0);
      else        drive(1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      if (data_valid === 1'b1) begin
        pulses++;
        rd = data_out;
      end
    end
    n_checks++;
    if (pulses != 1 || rd !== 16'hBEEF) begin
      n_errors++;
      $display("FAIL conflict_readback pulses=%0d dat=%h expected 1 BEEF", pulses, rd);
    end
  endtask

  task automatic test_reset_mid_burst();
    int pulses = 0;
    logic [15:0] got [$];
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 16'h2000 + 16'(2 * k), 16'h0);
      tick();
    end
    n_checks++;
    if (outstanding !== 4'd3) begin
      n_errors++;
      $display("FAIL midrst_before got=%0d expected=3", outstanding);
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;
    #1;
    n_checks++;
    if (data_valid !== 1'b0 || data_out !== 16'h0 || outstanding !== 4'd0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_async vld=%0b dat=%h out=%0d err=%0b expected all 0", data_valid, data_out, outstanding, err);
    end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (data_valid === 1'b1) pulses++;
      n_checks++;
      if (data_valid !== exp_vld || outstanding !== exp_out || err !== exp_err) begin
        n_errors++;
        $display("FAIL midrst_quiet k=%0d vld=%0b out=%0d err=%0b expected vld=%0b out=%0d err=%0b",
                 k, data_valid, outstanding, err, exp_vld, exp_out, exp_err);
      end
    end
    n_checks++;
    if (pulses != 0) begin
      n_errors++;
      $display("FAIL midrst_stray pulses=%0d expected=0", pulses);
    end
    for (int k = 0; k < 7; k++) begin
      if (k < 2) drive(1'b1, 1'b0, 16'h2004 + 16'(8 * k), 16'h0);
      else       drive(1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      n_checks++;
      if (data_valid !== exp_vld || data_out !== exp_dat) begin
        n_errors++;
        $display("FAIL midrst_read k=%0d vld=%0b dat=%h expected vld=%0b dat=%h", k, data_valid, data_out, exp_vld, exp_dat);
      end
      if (data_valid === 1'b1) got.push_back(data_out);
    end
    n_checks++;
    if (got.size() != 2 || got[0] !== 16'hA002 || got[1] !== 16'hA006) begin
      n_errors++;
      $display("FAIL midrst_contents words=%0d expected A002 A006", got.size());
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    int r;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 16'h5000 + 16'(2 * i), 16'($urandom));
      tick();
    end
    for (int k = 0; k < 406; k++) begin
      a = 16'h5000 + 16'(2 * $urandom_range(0, 7));
      r = int'($urandom_range(0, 99));
      if (k >= 400)      drive(1'b0, 1'b0, 16'h0, 16'h0);
      else if (r < 50)   drive(1'b1, 1'b0, a, 16'h0);
      else if (r < 75)   drive(1'b0, 1'b1, a, 16'($urandom));
      else if (r < 77)   drive(1'b1, 1'b1, a, 16'($urandom));
      else               drive(1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      n_checks++;
      if (data_valid !== exp_vld || data_out !== exp_dat || outstanding !== exp_out || err !== exp_err) begin
        n_errors++;
        $display("FAIL random k=%0d vld=%0b dat=%h out=%0d err=%0b expected vld=%0b dat=%h out=%0d err=%0b",
                 k, data_valid, data_out, outstanding, err, exp_vld, exp_dat, exp_out, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst();
    test_ordering();
    test_conflict();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
